chess_cursor_ctrl: RTL and testbench
====================================

// Module: chess_cursor_ctrl
// PURPOSE
//  Upstream of the file-letter and rank-digit seven-segment decoders: turns 5 raw push-buttons into
//  an 8x8 board cursor and a two-step from/to move selection. Drives 4-bit codes the decoders take:
//  file 0..7 (A..H), rank 1..8, 4'hF = blank. Emits a one-cycle move strobe for the game logic.
// PARAMETERS
//  DEBOUNCE_CYCLES  250000    consecutive stable synced cycles before a button state change is accepted
//  BLINK_HALF       12500000  cycles per blink half-period (used only with CURSOR_BLINK_EN)
// PORTS
//  clk            in   1  system clock; single clock domain
//  rst            in   1  synchronous, active-high reset
//  btn_up/down    in   1  raw, asynchronous, active-high rank buttons
//  btn_left/right in   1  raw, asynchronous, active-high file buttons
//  btn_sel        in   1  raw, asynchronous, active-high select button
//  cur_file_hex   out  4  cursor file code 0..7, or 4'hF when blanked
//  cur_rank_hex   out  4  cursor rank code 1..8, or 4'hF when blanked
//  from_file_hex  out  4  latched from-file 0..7; 4'hF in S_PICK_FROM
//  from_rank_hex  out  4  latched from-rank 1..8; 4'hF in S_PICK_FROM
//  move_valid     out  1  one-cycle strobe: move_from/move_to are valid
//  move_from      out  6  {file[2:0],rank_idx[2:0]}, rank_idx = rank-1
//  move_to        out  6  same encoding
//  picking_to     out  1  1 while in S_PICK_TO
// BEHAVIOUR
//  Reset (any cycle, aborts everything): cursor A1 (cur_file_hex=0, cur_rank_hex=1); from_* = 4'hF;
//   move_valid=0; move_from/move_to=0; state S_PICK_FROM; debounce counters, sync flops and debounced
//   states=0; blink phase=on. A button held through reset release gives no pulse until released/re-pressed.
//  Input path per button: 2-flop synchroniser -> counter; debounced state flips after synced value
//   differs from it for DEBOUNCE_CYCLES consecutive cycles (any agreement clears counter); press pulse
//   = 1 cycle on debounced 0->1. Release produces no pulse. Raw stable rise at cycle 0 -> pulse high at
//   cycle DEBOUNCE_CYCLES+2; registered outputs reflect it at cycle DEBOUNCE_CYCLES+3.
//  Cursor: internal file f[2:0], rank index r[2:0]; 3-bit modulo arithmetic. right f+1, left f-1,
//   up r+1, down r-1; H+right->A, A+left->H, 8+up->1, 1+down->8. cur_rank_hex = {1'b0,r}+1.
//   Same-cycle pulses: opposite pair on one axis cancels (no change); the two axes apply independently.
//  FSM (2 states, move pulses act in both):
//   S_PICK_FROM: sel -> latch from=(f,r) (pre-move value if move pulse coincides), go S_PICK_TO.
//   S_PICK_TO:   sel with (f,r)==from -> cancel: from_*=4'hF, no strobe, go S_PICK_FROM.
//                sel with (f,r)!=from -> next cycle move_valid=1, move_from=from, move_to=(f,r);
//                from_*=4'hF; go S_PICK_FROM. Comparison uses pre-move cursor.
//  move_from/move_to hold last issued move until next strobe or reset. Never two strobes back-to-back
//   (sel pulses are >= DEBOUNCE_CYCLES apart by construction).
// CONFIGURATION
//  CURSOR_BLINK_EN defined: free-running counter toggles phase every BLINK_HALF cycles; in S_PICK_TO,
//   off phase drives cur_file_hex=cur_rank_hex=4'hF; entering S_PICK_TO restarts counter, phase=on.
//   S_PICK_FROM always shows cursor steady.
//  CURSOR_BLINK_EN undefined: no blink counter; cursor always shown; BLINK_HALF unused.
// STRUCTURE
//  Shared package chess_pkg: state encoding (S_PICK_FROM=0, S_PICK_TO=1), BLANK_HEX=4'hF,
//   6-bit square width, pack/unpack of {file,rank_idx}; also used by the game-logic consumer.
//  Sub-module btn_debounce (sync + counter + rise pulse, parameter DEBOUNCE_CYCLES), instantiated x5.
//  Top holds cursor regs, FSM, from latch, move outputs, optional blink counter; all outputs registered.
// TESTING (bench uses DEBOUNCE_CYCLES=4, BLINK_HALF=8)
//  Reset -> A1 shown (0,1), from_* =F, move_valid=0; hold btn_right through rst release -> no move.
//  right x3, up x4 -> cursor (3,5)=D5; 3-cycle glitch on btn_up -> no change; timing check at +7 cycles.
//  From H8: right -> A8 (0,8); up -> A1 (0,1); left -> H1 (7,1); down -> H8 (7,8).
//  Sel at B1, move to B3, sel -> one-cycle move_valid, move_from=6'b001_000, move_to=6'b001_010, from_*=F.
//  Sel at E2, sel again at E2 -> cancel, no move_valid, state S_PICK_FROM; up+down same cycle -> no move.
//  CURSOR_BLINK_EN: in S_PICK_TO cursor codes alternate real/4'hF every 8 cycles; rst mid-blink -> A1 steady.

Source files
------------

// File: rtl/chess_pkg.sv
// Shared board/cursor definitions for the cursor controller and the game-logic consumer.
package chess_pkg;

    typedef enum logic {
        S_PICK_FROM = 1'b0,
        S_PICK_TO   = 1'b1
    } state_t;

    localparam logic [3:0] BLANK_HEX = 4'hF;
    localparam int         SQ_W      = 6;

    typedef logic [SQ_W-1:0] square_t;

    // Bit positions of the buttons inside the debounced press vector
    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;
    localparam int BTN_SEL   = 4;
    localparam int BTN_NUM   = 5;

    function automatic square_t pack_sq(input logic [2:0] file, input logic [2:0] rank_idx);
        return {file, rank_idx};
    endfunction

    function automatic logic [2:0] sq_file(input square_t sq);
        return sq[5:3];
    endfunction

    function automatic logic [2:0] sq_rank(input square_t sq);
        return sq[2:0];
    endfunction

    // Rank index 0..7 to the 1..8 digit code expected by the rank decoder
    function automatic logic [3:0] rank_hex(input logic [2:0] rank_idx);
        return {1'b0, rank_idx} + 4'd1;
    endfunction

endpackage

// File: rtl/chess_cursor_ctrl_if.sv
// Button inputs and display/move outputs of the chess cursor controller.
interface chess_cursor_ctrl_if;
    import chess_pkg::*;

    logic       btn_up;
    logic       btn_down;
    logic       btn_left;
    logic       btn_right;
    logic       btn_sel;
    logic [3:0] cur_file_hex;
    logic [3:0] cur_rank_hex;
    logic [3:0] from_file_hex;
    logic [3:0] from_rank_hex;
    logic       move_valid;
    square_t    move_from;
    square_t    move_to;
    logic       picking_to;

    modport master (
        output btn_up, btn_down, btn_left, btn_right, btn_sel,
        input  cur_file_hex, cur_rank_hex, from_file_hex, from_rank_hex,
        input  move_valid, move_from, move_to, picking_to
    );

    modport slave (
        input  btn_up, btn_down, btn_left, btn_right, btn_sel,
        output cur_file_hex, cur_rank_hex, from_file_hex, from_rank_hex,
        output move_valid, move_from, move_to, picking_to
    );

endinterface

// File: rtl/chess_cursor_ctrl_debounce.sv
// btn_debounce: 2-flop synchroniser, stability counter and one-cycle press pulse for one raw button.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_press
);

    localparam int             CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_state;
    logic             r_state_d;
    logic             r_armed;
    logic [1:0]       r_settle;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_state   <= 1'b0;
            r_state_d <= 1'b0;
            r_armed   <= 1'b0;
            r_settle  <= 2'd0;
            r_cnt     <= '0;
        end else begin
            r_sync1   <= i_btn;
            r_sync2   <= r_sync1;
            r_state_d <= r_state;

            if (r_sync2 == r_state) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_cnt   <= '0;
                r_state <= r_sync2;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            // Once the synchroniser holds real samples, arm only after seeing the button released,
            // so a button held through reset cannot produce a press.
            if (r_settle != 2'd2) begin
                r_settle <= r_settle + 2'd1;
            end else if (!r_sync2 && !r_state) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign o_press = r_state & ~r_state_d & r_armed;

endmodule

// File: rtl/chess_cursor_ctrl.sv
// Chess board cursor and two-step from/to move selection driven by five debounced buttons.
// Optional build macro CURSOR_BLINK_EN blinks the cursor codes while picking the destination.
module chess_cursor_ctrl
    import chess_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int BLINK_HALF      = 12500000
) (
    input  logic            clk,
    input  logic            rst,
    chess_cursor_ctrl_if.slave bus
);

    if (DEBOUNCE_CYCLES < 1 || BLINK_HALF < 1) begin : g_bad_param
        $error("chess_cursor_ctrl: DEBOUNCE_CYCLES and BLINK_HALF must be >= 1");
    end

    logic [BTN_NUM-1:0] w_raw;
    logic [BTN_NUM-1:0] w_press;

    assign w_raw = {bus.btn_sel, bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up};

    genvar gi;
    generate
        for (gi = 0; gi < BTN_NUM; gi++) begin : g_btn
            btn_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk     (clk),
                .rst     (rst),
                .i_btn   (w_raw[gi]),
                .o_press (w_press[gi])
            );
        end
    endgenerate

    logic w_up, w_down, w_left, w_right, w_sel;
    assign w_up    = w_press[BTN_UP];
    assign w_down  = w_press[BTN_DOWN];
    assign w_left  = w_press[BTN_LEFT];
    assign w_right = w_press[BTN_RIGHT];
    assign w_sel   = w_press[BTN_SEL];

    logic [2:0] r_file, r_rank;
    logic [2:0] w_file_next, w_rank_next;
    square_t    w_cur_sq;

    // Opposite presses on one axis cancel; 3-bit arithmetic gives the board wrap for free.
    always_comb begin
        w_file_next = r_file;
        w_rank_next = r_rank;
        if (w_right && !w_left) w_file_next = r_file + 3'd1;
        if (w_left && !w_right) w_file_next = r_file - 3'd1;
        if (w_up && !w_down)    w_rank_next = r_rank + 3'd1;
        if (w_down && !w_up)    w_rank_next = r_rank - 3'd1;
    end

    assign w_cur_sq = pack_sq(r_file, r_rank);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_file <= 3'd0;
            r_rank <= 3'd0;
        end else begin
            r_file <= w_file_next;
            r_rank <= w_rank_next;
        end
    end

    state_t  r_state, w_state_next;
    square_t r_from, w_from_next;
    logic    r_move_valid, w_move_valid_next;
    square_t r_move_from, w_move_from_next;
    square_t r_move_to, w_move_to_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_PICK_FROM;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_PICK_FROM: if (w_sel) w_state_next = S_PICK_TO;
            S_PICK_TO:   if (w_sel) w_state_next = S_PICK_FROM;
            default:     w_state_next = S_PICK_FROM;
        endcase
    end

    // Selections always use the cursor as it was before any coincident move press.
    always_comb begin
        w_from_next       = r_from;
        w_move_valid_next = 1'b0;
        w_move_from_next  = r_move_from;
        w_move_to_next    = r_move_to;
        case (r_state)
            S_PICK_FROM: begin
                if (w_sel) w_from_next = w_cur_sq;
            end
            S_PICK_TO: begin
                if (w_sel && (w_cur_sq != r_from)) begin
                    w_move_valid_next = 1'b1;
                    w_move_from_next  = r_from;
                    w_move_to_next    = w_cur_sq;
                end
            end
            default: ;
        endcase
    end

    logic w_show;

`ifdef CURSOR_BLINK_EN
    localparam int               BLINK_W    = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

    logic [BLINK_W-1:0] r_blink_cnt, w_blink_cnt_next;
    logic               r_blink_on, w_blink_on_next;

    // Counter runs only while staying in S_PICK_TO; entering it restarts in the on phase.
    always_comb begin
        w_blink_cnt_next = '0;
        w_blink_on_next  = 1'b1;
        if (r_state == S_PICK_TO && w_state_next == S_PICK_TO) begin
            if (r_blink_cnt == BLINK_LAST) begin
                w_blink_on_next = ~r_blink_on;
            end else begin
                w_blink_cnt_next = r_blink_cnt + 1'b1;
                w_blink_on_next  = r_blink_on;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
        end else begin
            r_blink_cnt <= w_blink_cnt_next;
            r_blink_on  <= w_blink_on_next;
        end
    end

    assign w_show = w_blink_on_next;
`else
    assign w_show = 1'b1;
`endif

    logic [3:0] r_cur_file_hex, r_cur_rank_hex;
    logic [3:0] r_from_file_hex, r_from_rank_hex;
    logic       r_picking_to;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_from          <= '0;
            r_move_valid    <= 1'b0;
            r_move_from     <= '0;
            r_move_to       <= '0;
            r_cur_file_hex  <= 4'd0;
            r_cur_rank_hex  <= 4'd1;
            r_from_file_hex <= BLANK_HEX;
            r_from_rank_hex <= BLANK_HEX;
            r_picking_to    <= 1'b0;
        end else begin
            r_from         <= w_from_next;
            r_move_valid   <= w_move_valid_next;
            r_move_from    <= w_move_from_next;
            r_move_to      <= w_move_to_next;
            r_cur_file_hex <= w_show ? {1'b0, w_file_next} : BLANK_HEX;
            r_cur_rank_hex <= w_show ? rank_hex(w_rank_next) : BLANK_HEX;
            r_picking_to   <= (w_state_next == S_PICK_TO);
            if (w_state_next == S_PICK_TO) begin
                r_from_file_hex <= {1'b0, sq_file(w_from_next)};
                r_from_rank_hex <= rank_hex(sq_rank(w_from_next));
            end else begin
                r_from_file_hex <= BLANK_HEX;
                r_from_rank_hex <= BLANK_HEX;
            end
        end
    end

    assign bus.cur_file_hex  = r_cur_file_hex;
    assign bus.cur_rank_hex  = r_cur_rank_hex;
    assign bus.from_file_hex = r_from_file_hex;
    assign bus.from_rank_hex = r_from_rank_hex;
    assign bus.move_valid    = r_move_valid;
    assign bus.move_from     = r_move_from;
    assign bus.move_to       = r_move_to;
    assign bus.picking_to    = r_picking_to;

endmodule

// File: tb/tb_chess_cursor_ctrl.sv
// Self-checking bench for chess_cursor_ctrl: cursor moves, wraps, debounce timing and move scoreboard.
module tb_chess_cursor_ctrl;

    localparam int N    = 4;
    localparam int HOLD = N + 4;

    localparam logic [4:0] UP = 5'b00001;
    localparam logic [4:0] DN = 5'b00010;
    localparam logic [4:0] LT = 5'b00100;
    localparam logic [4:0] RT = 5'b01000;
    localparam logic [4:0] SL = 5'b10000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks   = 0;
    int failures = 0;
    int strobes  = 0;

    logic [11:0] sb_q[$];
    logic        prev_mv = 1'b0;

    chess_cursor_ctrl_if bus ();

    chess_cursor_ctrl #(
        .DEBOUNCE_CYCLES(N),
        .BLINK_HALF(8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Scoreboard consumer: every strobe must match the oldest expected move.
    always @(negedge clk) begin
        if (!rst && bus.move_valid) begin
            strobes++;
            checks++;
            if (prev_mv) begin
                failures++;
                $display("FAIL strobe_single: move_valid high two cycles in a row");
            end
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL strobe_unexpected: from=%b to=%b, none expected", bus.move_from, bus.move_to);
            end else begin
                logic [11:0] exp_mv;
                exp_mv = sb_q.pop_front();
                if ({bus.move_from, bus.move_to} !== exp_mv)
                    begin
                        failures++;
                        $display("FAIL move_pair: got from=%b to=%b, want from=%b to=%b",
                                 bus.move_from, bus.move_to, exp_mv[11:6], exp_mv[5:0]);
                    end
            end
            $display("move strobe: from=%b to=%b", bus.move_from, bus.move_to);
        end
        prev_mv = bus.move_valid;
    end

    task automatic set_btns(input logic [4:0] v);
        bus.btn_up    = v[0];
        bus.btn_down  = v[1];
        bus.btn_left  = v[2];
        bus.btn_right = v[3];
        bus.btn_sel   = v[4];
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic press(input logic [4:0] v);
        @(negedge clk);
        set_btns(v);
        repeat (HOLD) @(negedge clk);
        set_btns(5'b0);
        repeat (HOLD) @(negedge clk);
        $display("press %b -> cursor (%0h,%0h) from (%0h,%0h) picking_to=%0b",
                 v, bus.cur_file_hex, bus.cur_rank_hex, bus.from_file_hex, bus.from_rank_hex, bus.picking_to);
    endtask

    task automatic test_reset();
        set_btns(5'b0);
        do_reset();
        checks++;
        if ({bus.cur_file_hex, bus.cur_rank_hex} !== 8'h01) begin
            failures++;
            $display("FAIL reset_cursor: got %h, want 01", {bus.cur_file_hex, bus.cur_rank_hex});
        end
        checks++;
        if ({bus.from_file_hex, bus.from_rank_hex} !== 8'hFF) begin
            failures++;
            $display("FAIL reset_from: got %h, want FF", {bus.from_file_hex, bus.from_rank_hex});
        end
        checks++;
        if ({bus.move_valid, bus.picking_to, bus.move_from, bus.move_to} !== 14'd0) begin
            failures++;
            $display("FAIL reset_move: got mv=%b pt=%b from=%b to=%b, want all 0",
                     bus.move_valid, bus.picking_to, bus.move_from, bus.move_to);
        end
    endtask

    task automatic test_held_through_reset();
        @(negedge clk);
        bus.btn_right = 1'b1;
        do_reset();
        repeat (20) @(negedge clk);
        bus.btn_right = 1'b0;
        repeat (HOLD + 4) @(negedge clk);
        checks++;
        if ({bus.cur_file_hex, bus.cur_rank_hex} !== 8'h01) begin
            failures++;
            $display("FAIL held_reset: got %h, want 01", {bus.cur_file_hex, bus.cur_rank_hex});
        end
    endtask

    task automatic test_cursor_move();
        repeat (3) press(RT);
        repeat (4) press(UP);
        checks++;
        if ({bus.cur_file_hex, bus.cur_rank_hex} !== 8'h35) begin
            failures++;
            $display("FAIL move_d5: got %h, want 35", {bus.cur_file_hex, bus.cur_rank_hex});
        end
    endtask

    task automatic test_glitch();
        @(negedge clk);
        bus.btn_up = 1'b1;
        repeat (N - 1) @(negedge clk);
        bus.btn_up = 1'b0;
        repeat (HOLD + 4) @(negedge clk);
        checks++;
        if ({bus.cur_file_hex, bus.cur_rank_hex} !== 8'h35) begin
            failures++;
            $display("FAIL glitch: got %h, want 35", {bus.cur_file_hex, bus.cur_rank_hex});
        end
    endtask

    task automatic test_timing();
        @(negedge clk);
        bus.btn_up = 1'b1;
        repeat (N + 2) @(negedge clk);
        checks++;
        if ({bus.cur_file_hex, bus.cur_rank_hex} !== 8'h35) begin
            failures++;
            $display("FAIL timing_early: got %h at +%0d, want 35", {bus.cur_file_hex, bus.cur_rank_hex}, N + 2);
        end
        @(negedge clk);
        checks++;
        if ({bus.cur_file_hex, bus.cur_rank_hex} !== 8'h36) begin
            failures++;
            $display("FAIL timing_edge: got %h at +%0d, want 36", {bus.cur_file_hex, bus.cur_rank_hex}, N + 3);
        end
        bus.btn_up = 1'b0;
        repeat (HOLD) @(negedge clk);
    endtask

    task automatic test_wrap();
        logic [4:0] dirs [4];
        logic [7:0] exps [4];
        repeat (2) press(UP);
        repeat (4) press(RT);
        checks++;
        if ({bus.cur_file_hex, bus.cur_rank_hex} !== 8'h78) begin
            failures++;
            $display("FAIL wrap_h8: got %h, want 78", {bus.cur_file_hex, bus.cur_rank_hex});
        end
        dirs = '{RT, UP, LT, DN};
        exps = '{8'h08, 8'h01, 8'h71, 8'h78};
        for (int i = 0; i < 4; i++) begin
            press(dirs[i]);
            checks++;
            if ({bus.cur_file_hex, bus.cur_rank_hex} !== exps[i]) begin
                failures++;
                $display("FAIL wrap_%0d: got %h, want %h", i, {bus.cur_file_hex, bus.cur_rank_hex}, exps[i]);
            end
        end
    endtask

    task automatic test_move();
        int s0;
        do_reset();
        press(RT);
        press(SL);
        checks++;
        if ({bus.picking_to, bus.from_file_hex, bus.from_rank_hex} !== 9'h1_11) begin
            failures++;
            $display("FAIL from_latch_b1: got pt=%b from=%h, want pt=1 from=11",
                     bus.picking_to, {bus.from_file_hex, bus.from_rank_hex});
        end
        repeat (2) press(UP);
        checks++;
        if ({bus.cur_file_hex, bus.cur_rank_hex, bus.from_file_hex, bus.from_rank_hex} !== 16'h1311) begin
            failures++;
            $display("FAIL b3_pending: got %h, want 1311",
                     {bus.cur_file_hex, bus.cur_rank_hex, bus.from_file_hex, bus.from_rank_hex});
        end
        s0 = strobes;
        sb_q.push_back({6'b001_000, 6'b001_010});
        press(SL);
        checks++;
        if (strobes !== s0 + 1) begin
            failures++;
            $display("FAIL move_count: got %0d strobes, want %0d", strobes - s0, 1);
        end
        checks++;
        if ({bus.picking_to, bus.from_file_hex, bus.from_rank_hex, bus.move_from, bus.move_to}
            !== {1'b0, 8'hFF, 6'b001_000, 6'b001_010}) begin
            failures++;
            $display("FAIL after_move: got pt=%b from=%h mf=%b mt=%b, want pt=0 from=FF mf=001000 mt=001010",
                     bus.picking_to, {bus.from_file_hex, bus.from_rank_hex}, bus.move_from, bus.move_to);
        end
    endtask

    task automatic test_cancel();
        int s0;
        repeat (3) press(RT);
        press(DN);
        s0 = strobes;
        press(SL);
        checks++;
        if ({bus.picking_to, bus.from_file_hex, bus.from_rank_hex} !== 9'h1_42) begin
            failures++;
            $display("FAIL from_latch_e2: got pt=%b from=%h, want pt=1 from=42",
                     bus.picking_to, {bus.from_file_hex, bus.from_rank_hex});
        end
        press(SL);
        checks++;
        if ({bus.picking_to, bus.from_file_hex, bus.from_rank_hex} !== 9'h0_FF || strobes !== s0) begin
            failures++;
            $display("FAIL cancel: got pt=%b from=%h strobes=%0d, want pt=0 from=FF strobes=0",
                     bus.picking_to, {bus.from_file_hex, bus.from_rank_hex}, strobes - s0);
        end
        press(UP | DN);
        checks++;
        if ({bus.cur_file_hex, bus.cur_rank_hex} !== 8'h42) begin
            failures++;
            $display("FAIL up_down_cancel: got %h, want 42", {bus.cur_file_hex, bus.cur_rank_hex});
        end
        press(LT | RT | UP);
        checks++;
        if ({bus.cur_file_hex, bus.cur_rank_hex} !== 8'h43) begin
            failures++;
            $display("FAIL axes_indep: got %h, want 43", {bus.cur_file_hex, bus.cur_rank_hex});
        end
        checks++;
        if ({bus.move_from, bus.move_to} !== {6'b001_000, 6'b001_010}) begin
            failures++;
            $display("FAIL move_hold: got mf=%b mt=%b, want 001000 001010", bus.move_from, bus.move_to);
        end
    endtask

    task automatic test_coincident();
        press(SL | RT);
        checks++;
        if ({bus.cur_file_hex, bus.cur_rank_hex, bus.from_file_hex, bus.from_rank_hex} !== 16'h5343) begin
            failures++;
            $display("FAIL sel_with_move: got %h, want 5343",
                     {bus.cur_file_hex, bus.cur_rank_hex, bus.from_file_hex, bus.from_rank_hex});
        end
        sb_q.push_back({6'b100_010, 6'b101_010});
        press(SL | LT);
        checks++;
        if ({bus.cur_file_hex, bus.cur_rank_hex, bus.from_file_hex, bus.from_rank_hex} !== 16'h43FF) begin
            failures++;
            $display("FAIL to_with_move: got %h, want 43FF",
                     {bus.cur_file_hex, bus.cur_rank_hex, bus.from_file_hex, bus.from_rank_hex});
        end
    endtask

    task automatic test_display_in_pick_to();
        int waited;
        logic [7:0] exp_cur;
        @(negedge clk);
        bus.btn_sel = 1'b1;
        waited = 0;
        while (bus.picking_to !== 1'b1 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (bus.picking_to !== 1'b1) begin
            failures++;
            $display("FAIL enter_pick_to: picking_to=%b after %0d cycles, want 1", bus.picking_to, waited);
        end
        for (int k = 0; k < 32; k++) begin
`ifdef CURSOR_BLINK_EN
            exp_cur = (((k / 8) % 2) == 0) ? 8'h43 : 8'hFF;
`else
            exp_cur = 8'h43;
`endif
            checks++;
            if ({bus.cur_file_hex, bus.cur_rank_hex} !== exp_cur) begin
                failures++;
                $display("FAIL pick_to_display_k%0d: got %h, want %h", k, {bus.cur_file_hex, bus.cur_rank_hex}, exp_cur);
            end
            if (k == 27) bus.btn_sel = 1'b0;
            @(negedge clk);
        end
        $display("pick_to display sampled over 32 cycles");
        // Reset lands in the middle of an off phase when blinking is built in.
        repeat (10) @(negedge clk);
        do_reset();
        for (int k = 0; k < 20; k++) begin
            checks++;
            if ({bus.cur_file_hex, bus.cur_rank_hex, bus.picking_to} !== {8'h01, 1'b0}) begin
                failures++;
                $display("FAIL reset_steady_k%0d: got %h pt=%b, want 01 pt=0",
                         k, {bus.cur_file_hex, bus.cur_rank_hex}, bus.picking_to);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        set_btns(5'b0);
        test_reset();
        test_held_through_reset();
        test_cursor_move();
        test_glitch();
        test_timing();
        test_wrap();
        test_move();
        test_cancel();
        test_coincident();
        test_display_in_pick_to();
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d expected moves never seen, want 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
